ahb_decode_mux: RTL

// - AHB-Lite address decoder plus slave-to-master response multiplexer for a single-master bus.
// - Decodes HADDR into one-hot slave selects; HSEL_DEF selects the default (error) slave when no region matches.
// - Registers the data-phase select and routes the selected slave's HRDATA/HREADYOUT/HRESP back to the master.
// - Built-in stall watchdog: a slave stalling a data phase too long has the transfer terminated with a 2-cycle ERROR.

---
 rtl/ahb_decode_mux_pkg.sv | 32 +++
 rtl/ahb_stall_watchdog.sv | 78 +++++++
 rtl/ahb_decode_mux.sv | 110 +++++++++++
 3 files changed

// File: rtl/ahb_decode_mux_pkg.sv
// Shared AHB-Lite transfer/response codes and stall-watchdog state encoding
// for the single-master address decoder and response multiplexer.
package ahb_decode_mux_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [7:0] TMO_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        S_NORM = 2'b00,
        S_ERR1 = 2'b01,
        S_ERR2 = 2'b10
    } wd_state_e;

    // A data phase is only owed a response for NONSEQ/SEQ transfers.
    function automatic logic is_active(input logic [1:0] htrans);
        logic act;
        case (htrans)
            HTRANS_IDLE, HTRANS_BUSY: act = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            default: act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/ahb_stall_watchdog.sv
// Data-phase stall watchdog: terminates an over-long slave stall with a
// two-cycle ERROR and keeps a sticky flag plus saturating termination count.
module ahb_stall_watchdog
    import ahb_decode_mux_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       i_dact,
    input  logic       i_dsel_def,
    input  logic       i_hreadyout,
    input  logic       i_tmo_clr,
    output logic       o_force_err,
    output logic       o_force_ready,
    output logic       o_tmo_flag,
    output logic [7:0] o_tmo_cnt
);

    localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

    wd_state_e  r_state;
    wd_state_e  w_state_nxt;
    logic [7:0] r_wcnt;
    logic       r_tmo_flag;
    logic [7:0] r_tmo_cnt;
    logic       w_stall;
    logic       w_fire;

    // The default slave is trusted to terminate on its own, so it is never watched.
    assign w_stall = (r_state == S_NORM) && i_dact && !i_dsel_def && !i_hreadyout;
    assign w_fire  = w_stall && (r_wcnt == WCNT_LAST);

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        w_state_nxt   = r_state;
        o_force_err   = 1'b0;
        o_force_ready = 1'b1;
        case (r_state)
            S_NORM: if (w_fire) w_state_nxt = S_ERR1;
            S_ERR1: begin
                w_state_nxt   = S_ERR2;
                o_force_err   = 1'b1;
                o_force_ready = 1'b0;
            end
            S_ERR2: begin
                w_state_nxt   = S_NORM;
                o_force_err   = 1'b1;
                o_force_ready = 1'b1;
            end
            default: w_state_nxt = S_NORM;
        endcase
    end

    // NOTE: registered state is updated with non-blocking assignments only.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= S_NORM;
            r_wcnt     <= 8'd0;
            r_tmo_flag <= 1'b0;
            r_tmo_cnt  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= (w_stall && !w_fire) ? r_wcnt + 8'd1 : 8'd0;
            if (i_tmo_clr) begin
                r_tmo_flag <= 1'b0;
                r_tmo_cnt  <= 8'd0;
            end else if (w_fire) begin
                r_tmo_flag <= 1'b1;
                if (r_tmo_cnt != TMO_CNT_MAX) r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
        end
    end

    assign o_tmo_flag = r_tmo_flag;
    assign o_tmo_cnt  = r_tmo_cnt;

endmodule

// File: rtl/ahb_decode_mux.sv
// AHB-Lite address decoder and slave-to-master response multiplexer for a
// single-master bus, with a stall watchdog that can override the response.
module ahb_decode_mux
    import ahb_decode_mux_pkg::*;
#(
    parameter int               NS      = 4,
    parameter logic [NS*32-1:0] BASE    = '0,
    parameter logic [NS*32-1:0] MASK    = '0,
    parameter int               TIMEOUT = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    output logic [NS-1:0]    HSEL_S,
    output logic             HSEL_DEF,
    input  logic [NS*32-1:0] HRDATA_S,
    input  logic [NS-1:0]    HREADYOUT_S,
    input  logic [NS-1:0]    HRESP_S,
    input  logic [31:0]      HRDATA_DEF,
    input  logic             HREADYOUT_DEF,
    input  logic             HRESP_DEF,
    output logic             HREADY,
    output logic             HRESP,
    output logic [31:0]      HRDATA,
    input  logic             TMO_CLR,
    output logic             TMO_FLAG,
    output logic [7:0]       TMO_CNT
);

    logic [NS-1:0] w_hsel_s;
    logic          w_hsel_def;
    logic          w_found;
    logic [NS:0]   r_dsel;
    logic          r_dact;
    logic [31:0]   w_sel_rdata;
    logic          w_sel_ready;
    logic          w_sel_resp;
    logic          w_force_err;
    logic          w_force_ready;

    // Lowest-numbered matching region wins; no match falls through to the default slave.
    always_comb begin
        w_hsel_s = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (!w_found && ((HADDR & MASK[32*i +: 32]) == BASE[32*i +: 32])) begin
                w_hsel_s[i] = 1'b1;
                w_found     = 1'b1;
            end
        end
        w_hsel_def = !w_found;
    end

    assign HSEL_S   = w_hsel_s;
    assign HSEL_DEF = w_hsel_def;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dsel <= (NS+1)'(1) << NS;
            r_dact <= 1'b0;
        end else if (HREADY) begin
            r_dsel <= {w_hsel_def, w_hsel_s};
            r_dact <= is_active(HTRANS);
        end
    end

    // Data-phase select is one-hot, so an AND-OR mux suffices.
    always_comb begin
        w_sel_rdata = r_dsel[NS] ? HRDATA_DEF : 32'd0;
        w_sel_ready = r_dsel[NS] & HREADYOUT_DEF;
        w_sel_resp  = r_dsel[NS] & HRESP_DEF;
        for (int i = 0; i < NS; i++) begin
            w_sel_rdata = w_sel_rdata | (HRDATA_S[32*i +: 32] & {32{r_dsel[i]}});
            w_sel_ready = w_sel_ready | (HREADYOUT_S[i] & r_dsel[i]);
            w_sel_resp  = w_sel_resp  | (HRESP_S[i] & r_dsel[i]);
        end
    end

    ahb_stall_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .i_dact        (r_dact),
        .i_dsel_def    (r_dsel[NS]),
        .i_hreadyout   (w_sel_ready),
        .i_tmo_clr     (TMO_CLR),
        .o_force_err   (w_force_err),
        .o_force_ready (w_force_ready),
        .o_tmo_flag    (TMO_FLAG),
        .o_tmo_cnt     (TMO_CNT)
    );

    // Once the watchdog takes over, the stalled slave is ignored entirely.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        HRDATA = 32'd0;
        if (w_force_err) begin
            HREADY = w_force_ready;
            HRESP  = HRESP_ERROR;
        end else if (r_dact) begin
            HREADY = w_sel_ready;
            HRESP  = w_sel_resp;
            HRDATA = w_sel_rdata;
        end
    end

endmodule
